// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash reader.
// Provides the READ opcode, per-phase bit counts, the controller state type and
// a byte-order helper for assembling the read word.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;

  localparam int unsigned CMD_BITS   = 8;
  localparam int unsigned ADDR_BITS  = 24;
  localparam int unsigned DATA_BITS  = 32;
  localparam int unsigned TOTAL_BITS = CMD_BITS + ADDR_BITS + DATA_BITS;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    GAP
  } state_t;

  // The receive shifter holds the first byte in its top bits; the first byte
  // read belongs in the lowest byte lane of the output word.
  function automatic logic [31:0] pack_bytes(input logic [31:0] rx);
    return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SPI mode-0 serial clock generator.
// Divides clk so that SCK toggles every CLK_DIV cycles while enabled.
// rise/fall are one-cycle strobes asserted in the cycle whose closing clk edge
// drives SCK high/low, so logic using them acts on the same edge as SCK.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   en   - run the divider; when low SCK is parked low and the counter cleared
//   sck  - registered serial clock
//   rise - SCK goes high at the next clk edge
//   fall - SCK goes low at the next clk edge
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          at_last;

  assign at_last = en && (cnt == LAST);
  assign rise    = at_last && !sck;
  assign fall    = at_last && sck;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (at_last) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// SPI flash reader: issues READ (0x03) + 24-bit address and returns 32 bits.
// A one-entry address buffer lets one request queue behind a running
// transaction. Results are held until acknowledged; no new transaction starts
// while a result is pending. SPI_SS stays high for at least CS_GAP cycles
// between transactions.
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   SPI_SCK/SS/MOSI   - flash clock (mode 0), chip select (active low), data out
//   SPI_MISO          - flash data in
//   addr_buffer_free  - address buffer empty; addr_en is accepted
//   addr_en/addr_data - one-cycle request strobe and 24-bit byte address
//   rd_data_available - rd_data valid, held until rd_ack
//   rd_ack            - consumer releases rd_data
//   rd_data           - bytes addr..addr+3 in lanes [7:0]..[31:24]
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        SPI_SCK,
  output logic        SPI_SS,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO,
  output logic        addr_buffer_free,
  input  logic        addr_en,
  input  logic [23:0] addr_data,
  output logic        rd_data_available,
  input  logic        rd_ack,
  output logic [31:0] rd_data
);

  localparam int unsigned BW = $clog2(TOTAL_BITS + 1);
  localparam int unsigned GW = $clog2(CS_GAP + 1);
  // Counts CS_GAP-1 down to 0, so GAP lasts exactly CS_GAP cycles.
  localparam logic [GW-1:0] GAP_LOAD = GW'(CS_GAP - 1);

  state_t        state;
  logic [23:0]   buf_addr;
  logic [31:0]   tx_sh;
  logic [31:0]   rx_sh;
  logic [BW-1:0] bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic          sck_en;
  logic          sck_rise;
  logic          sck_fall;

  assign sck_en = (state == CMD) || (state == ADDR) || (state == DATA);

  spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (sck_en),
    .sck  (SPI_SCK),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= GAP;
      gap_cnt           <= GAP_LOAD;
      SPI_SS            <= 1'b1;
      SPI_MOSI          <= 1'b0;
      addr_buffer_free  <= 1'b1;
      buf_addr          <= '0;
      tx_sh             <= '0;
      rx_sh             <= '0;
      bit_cnt           <= '0;
      rd_data_available <= 1'b0;
      rd_data           <= '0;
    end else begin
      if (addr_en && addr_buffer_free) begin
        buf_addr         <= addr_data;
        addr_buffer_free <= 1'b0;
      end
      if (rd_ack && rd_data_available) begin
        rd_data_available <= 1'b0;
      end
      // Strobes only fire while the divider runs, i.e. in CMD/ADDR/DATA.
      if (sck_rise) begin
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (sck_fall) begin
        tx_sh    <= {tx_sh[30:0], 1'b0};
        SPI_MOSI <= tx_sh[30];
      end

      unique case (state)
        IDLE: begin
          if (!addr_buffer_free && !rd_data_available) begin
            state            <= CMD;
            SPI_SS           <= 1'b0;
            tx_sh            <= {CMD_READ, buf_addr};
            SPI_MOSI         <= CMD_READ[7];
            addr_buffer_free <= 1'b1;
            bit_cnt          <= '0;
          end
        end
        CMD: begin
          if (sck_rise && bit_cnt == BW'(CMD_BITS - 1)) begin
            state <= ADDR;
          end
        end
        ADDR: begin
          if (sck_rise && bit_cnt == BW'(CMD_BITS + ADDR_BITS - 1)) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (sck_rise) begin
            rx_sh <= {rx_sh[30:0], SPI_MISO};
          end
          // Falling edge after the final rising edge closes the transaction.
          if (sck_fall && bit_cnt == BW'(TOTAL_BITS)) begin
            state             <= GAP;
            gap_cnt           <= GAP_LOAD;
            SPI_SS            <= 1'b1;
            SPI_MOSI          <= 1'b0;
            rd_data           <= pack_bytes(rx_sh);
            rd_data_available <= 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          state   <= GAP;
          gap_cnt <= GAP_LOAD;
          SPI_SS  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Self-checking bench for spi_flash_reader with a behavioural mode-0 flash.
module tb_spi_flash_reader;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned CS_GAP  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        SPI_SCK, SPI_SS, SPI_MOSI;
  logic        SPI_MISO;
  logic        addr_buffer_free;
  logic        addr_en;
  logic [23:0] addr_data;
  logic        rd_data_available;
  logic        rd_ack;
  logic [31:0] rd_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_flash_reader #(
    .CLK_DIV(CLK_DIV),
    .CS_GAP (CS_GAP)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .SPI_SCK           (SPI_SCK),
    .SPI_SS            (SPI_SS),
    .SPI_MOSI          (SPI_MOSI),
    .SPI_MISO          (SPI_MISO),
    .addr_buffer_free  (addr_buffer_free),
    .addr_en           (addr_en),
    .addr_data         (addr_data),
    .rd_data_available (rd_data_available),
    .rd_ack            (rd_ack),
    .rd_data           (rd_data)
  );

  // Flash model: shifts in command+address on rising SCK, drives data on
  // falling SCK, wraps at the top of the 24-bit space.
  int          m_cnt = 0;
  int          last_cnt = 0;
  logic [31:0] m_in = '0;
  logic [31:0] last_in = '0;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h000010: flash_byte = 8'h11;
      24'h000011: flash_byte = 8'h22;
      24'h000012: flash_byte = 8'h33;
      24'h000013: flash_byte = 8'h44;
      24'h000014: flash_byte = 8'h55;
      24'h000015: flash_byte = 8'h66;
      24'h000016: flash_byte = 8'h77;
      24'h000017: flash_byte = 8'h88;
      24'hFFFFFE: flash_byte = 8'hA1;
      24'hFFFFFF: flash_byte = 8'hB2;
      24'h000000: flash_byte = 8'hC3;
      24'h000001: flash_byte = 8'hD4;
      default:    flash_byte = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  always @(negedge SPI_SS) begin
    m_cnt = 0;
    m_in  = '0;
  end

  always @(posedge SPI_SS) begin
    last_cnt = m_cnt;
    last_in  = m_in;
  end

  always @(posedge SPI_SCK) begin
    if (SPI_SS === 1'b0) begin
      if (m_cnt < 32) m_in = {m_in[30:0], SPI_MOSI};
      m_cnt++;
    end
  end

  always @(negedge SPI_SCK) begin
    int          idx;
    logic [23:0] a;
    logic [7:0]  b;
    if (SPI_SS === 1'b0 && m_cnt >= 32) begin
      idx      = m_cnt - 32;
      a        = m_in[23:0] + 24'(idx / 8);
      b        = flash_byte(a);
      SPI_MISO = b[7 - (idx % 8)];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_addr(input logic [23:0] a);
    @(negedge clk);
    addr_en   = 1'b1;
    addr_data = a;
    @(negedge clk);
    addr_en   = 1'b0;
  endtask

  task automatic wait_avail(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rd_data_available === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic ack();
    @(negedge clk);
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
  endtask

  task automatic wait_ss_low(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (SPI_SS === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [23:0] addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ss_bad;
    int data_bad;
    int free_bad;
    int avail_bad;
    bit ok;

    rst       = 1'b1;
    addr_en   = 1'b0;
    addr_data = '0;
    rd_ack    = 1'b0;
    SPI_MISO  = 1'b0;

    vecs[0] = '{addr: 24'h000010, exp_data: 32'h44332211};
    vecs[1] = '{addr: 24'h000014, exp_data: 32'h88776655};
    vecs[2] = '{addr: 24'hFFFFFE, exp_data: 32'hD4C3B2A1};
    vecs[3] = '{addr: 24'h123456, exp_data: 32'h03020D0C};

    repeat (3) @(negedge clk);
    check("rst_ss",    32'(SPI_SS), 32'd1);
    check("rst_sck",   32'(SPI_SCK), 32'd0);
    check("rst_mosi",  32'(SPI_MOSI), 32'd0);
    check("rst_free",  32'(addr_buffer_free), 32'd1);
    check("rst_avail", 32'(rd_data_available), 32'd0);
    check("rst_data",  rd_data, 32'h0);
    rst = 1'b0;

    // Single reads, including wrap past the top of the address space.
    for (int v = 0; v < 4; v++) begin
      send_addr(vecs[v].addr);
      check($sformatf("v%0d_free_drop", v), 32'(addr_buffer_free), 32'd0);
      wait_avail($sformatf("v%0d_done", v));
      check($sformatf("v%0d_data", v), rd_data, vecs[v].exp_data);
      check($sformatf("v%0d_mosi", v), last_in, {8'h03, vecs[v].addr});
      check($sformatf("v%0d_sck_rises", v), 32'(last_cnt), 32'd64);
      check($sformatf("v%0d_ss_high", v), 32'(SPI_SS), 32'd1);
      ack();
      check($sformatf("v%0d_ack_clear", v), 32'(rd_data_available), 32'd0);
    end

    // Queued request, ignored second strobe, exact restart after the gap.
    send_addr(24'h000010);
    wait_ss_low("bb_start");
    send_addr(24'h000014);
    check("bb_queued", 32'(addr_buffer_free), 32'd0);
    send_addr(24'hABCDEF);
    wait_avail("bb_first_done");
    check("bb_first_data", rd_data, 32'h44332211);
    rd_ack = 1'b1;
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      rd_ack = 1'b0;
      n++;
      if (SPI_SS === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("bb_restart_seen", 32'(ok), 32'd1);
    check("bb_gap_len", 32'(n), 32'(CS_GAP + 1));
    check("bb_free_after_start", 32'(addr_buffer_free), 32'd1);
    wait_avail("bb_second_done");
    check("bb_second_data", rd_data, 32'h88776655);
    check("bb_second_mosi", last_in, 32'h03000014);
    ack();

    // Back-pressure: pending result blocks a queued request.
    send_addr(24'h000010);
    wait_avail("bp_first_done");
    send_addr(24'h000014);
    ss_bad = 0; data_bad = 0; free_bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (SPI_SS !== 1'b1) ss_bad++;
      if (rd_data !== 32'h44332211) data_bad++;
      if (addr_buffer_free !== 1'b0) free_bad++;
    end
    check("bp_ss_high", 32'(ss_bad), 32'd0);
    check("bp_data_held", 32'(data_bad), 32'd0);
    check("bp_free_low", 32'(free_bad), 32'd0);
    check("bp_avail_held", 32'(rd_data_available), 32'd1);
    ack();
    wait_avail("bp_second_done");
    check("bp_second_data", rd_data, 32'h88776655);
    ack();

    // Reset in the address phase with a request queued.
    send_addr(24'h123456);
    wait_ss_low("rs_start");
    send_addr(24'h000014);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (m_cnt >= 16) begin
        ok = 1'b1;
        break;
      end
    end
    check("rs_in_addr", 32'(ok), 32'd1);
    check("rs_queued", 32'(addr_buffer_free), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rs_ss", 32'(SPI_SS), 32'd1);
    check("rs_sck", 32'(SPI_SCK), 32'd0);
    check("rs_free", 32'(addr_buffer_free), 32'd1);
    check("rs_data", rd_data, 32'h0);
    rst = 1'b0;
    ss_bad = 0; avail_bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (SPI_SS !== 1'b1) ss_bad++;
      if (rd_data_available !== 1'b0) avail_bad++;
    end
    check("rs_no_restart", 32'(ss_bad), 32'd0);
    check("rs_no_avail", 32'(avail_bad), 32'd0);
    send_addr(24'h000010);
    wait_avail("rs_recover_done");
    check("rs_recover_data", rd_data, 32'h44332211);
    ack();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
